mem_tile_sram_arb: RTL and testbench
====================================

// Module: mem_tile_sram_arb
// PURPOSE
//  Shares the single-port, 1-cycle-latency SRAM macro array of the memory tile between NumReq
//  OBI-style requesters, e.g. the NoC path after the atop resolver plus a scrubber/init engine.
//  Round-robin arbitration, plus a bounded lock so one requester can issue back-to-back beats
//  (RMW/atomic sequences). Routes each response back to its issuer one cycle after the grant.
// PARAMETERS
//  NumReq        2    number of requesters (>=1)
//  AddrWidth     17   SRAM word-address width
//  DataWidth     512  data width; byte enables are DataWidth/8
//  MaxLockCycles 8    max consecutive locked beats for one owner (>=1)
// PORTS
//  clk_i        in   1                      clock
//  rst_ni       in   1                      async active-low reset
//  req_i        in   NumReq                 request per requester
//  gnt_o        out  NumReq                 grant; handshake = req_i[i] & gnt_o[i]
//  we_i         in   NumReq                 1 = write
//  lock_i       in   NumReq                 request to keep the port after this beat
//  addr_i       in   NumReq x AddrWidth     word address
//  wdata_i      in   NumReq x DataWidth     write data
//  be_i         in   NumReq x DataWidth/8   byte enables
//  rvalid_o     out  NumReq                 response valid, exactly one per handshake
//  rdata_o      out  DataWidth              read data, shared, qualified by rvalid_o
//  mem_req_o    out  1                      macro request
//  mem_gnt_i    in   1                      macro accepts (tie 1 if never stalls)
//  mem_we_o     out  1                      macro write enable
//  mem_addr_o   out  AddrWidth              macro address
//  mem_wdata_o  out  DataWidth              macro write data
//  mem_be_o     out  DataWidth/8            macro byte enables
//  mem_rdata_i  in   DataWidth              macro read data, 1 cycle after an accepted read
// BEHAVIOUR
//  State
//  - rr_ptr_q, lock_act_q, lock_own_q, lock_cnt_q, rsp_vld_q, rsp_sel_q.
//  - Reset: all state 0; rvalid_o=0; mem_req_o=0; gnt_o=0 while no req_i is set.
//  Winner selection (combinational)
//  - If lock_act_q & req_i[lock_own_q]: winner = lock_own_q.
//  - Else: first set req_i scanning from rr_ptr_q upward, modulo NumReq.
//  - mem_req_o = |req_i. mem_we/addr/wdata/be_o = the winner's inputs.
//  - gnt_o[winner] = mem_gnt_i; all other gnt_o bits are 0. Zero-cycle grant path.
//  - A winner may change in a cycle without a handshake (OBI permits this before gnt).
//  Handshake (hs = mem_req_o & mem_gnt_i)
//  - Without hs, no state changes; this includes lock_cnt_q.
//  - On hs, when the lock is inactive or is released this cycle: rr_ptr_q <= (winner+1) % NumReq.
//    While the lock holds, rr_ptr_q is unchanged.
//  - Lock entry: hs & lock_i[winner] & !lock_act_q & MaxLockCycles>1
//      -> lock_act_q=1, lock_own_q=winner, lock_cnt_q=1.
//  - Lock continue: hs by the owner with lock_i=1 and lock_cnt_q+1 < MaxLockCycles
//      -> lock_cnt_q++.
//  - Lock release (lock_act_q=0, lock_cnt_q=0) on any of:
//      - owner hs with lock_i=0;
//      - owner hs that reaches lock_cnt_q+1 == MaxLockCycles (forced);
//      - req_i[owner]=0 in any cycle.
//  - Locked beats including the first never exceed MaxLockCycles. After a forced release,
//    arbitration resumes after the owner, so every other requester is served before the owner
//    is served again.
//  Response
//  - rsp_vld_q <= hs; rsp_sel_q <= winner.
//  - rvalid_o[i] = rsp_vld_q & (rsp_sel_q==i). One-cycle latency for both reads and writes.
//  - rdata_o = mem_rdata_i (pass-through); meaningful only for read responses.
//  - No rready: requesters must sink responses. Back-to-back handshakes give back-to-back rvalid.
//  Boundaries
//  - NumReq=1: pure pass-through with lock bookkeeping only.
//  - Reset mid-operation: a pending rvalid is dropped; lock and rr_ptr_q clear.
//  - Simultaneous release and new lock_i from another requester in one cycle: release first;
//    the newcomer can lock only on its own later handshake.
// TESTING
//  - Reset: release with req_i=0 -> rvalid_o=0, gnt_o=0, mem_req_o=0.
//  - RR fairness: req_i=2'b11 constant, mem_gnt_i=1 -> grants alternate 0,1,0,1;
//    rvalid_o follows each grant 1 cycle later.
//  - Read path: req0 read addr 0x10 -> next cycle rvalid_o[0]=1 and rdata_o=macro word at 0x10.
//  - Lock: req_i=2'b11, lock_i[0]=1 held, MaxLockCycles=8 -> 8 consecutive grants to 0, then
//    grant to 1, then 0 again.
//  - Early release: lock_i[0] drops after 3 beats -> 4th beat granted, then requester 1 wins.
//  - Stall: mem_gnt_i=0 for 5 cycles mid-lock -> no rvalid, lock_cnt_q frozen, output signals
//    stable; resumes correctly.

Source files
------------

// File: rtl/mem_tile_sram_arb.sv
// ---------------------------------------------------------------------------
// mem_tile_sram_arb
//   Shares one single-port, 1-cycle-latency SRAM macro between NumReq
//   OBI-style requesters. Round-robin arbitration, plus a bounded lock that
//   lets one requester issue up to MaxLockCycles back-to-back beats
//   (RMW / atomic sequences). Each handshake produces exactly one response,
//   routed back to its issuer one cycle after the grant.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/gnt_o            per-requester request / grant (zero-cycle grant)
//   we_i, lock_i           per-requester write enable / keep-port request
//   addr_i, wdata_i, be_i  per-requester word address, write data, byte enables
//   rvalid_o               per-requester response valid
//   rdata_o                shared read data, qualified by rvalid_o
//   mem_req_o/mem_gnt_i    macro request / accept
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o   macro command (winner's inputs)
//   mem_rdata_i            macro read data, one cycle after an accepted read
// ---------------------------------------------------------------------------
module mem_tile_sram_arb #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned AddrWidth     = 17,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned MaxLockCycles = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_i,
    output logic [NumReq-1:0]                    gnt_o,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq-1:0]                    lock_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
    output logic [NumReq-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic                                 mem_we_o,
    output logic [AddrWidth-1:0]                 mem_addr_o,
    output logic [DataWidth-1:0]                 mem_wdata_o,
    output logic [DataWidth/8-1:0]               mem_be_o,
    input  logic [DataWidth-1:0]                 mem_rdata_i
);

    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW   = $clog2(MaxLockCycles + 1);
    localparam bit          LockEn = (MaxLockCycles > 1);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_act_q, lock_act_d;
    logic [IdxW-1:0] lock_own_q, lock_own_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic [IdxW-1:0] rsp_sel_q, rsp_sel_d;

    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] cand;
    logic            found;
    logic            req_any;
    logic            hs;
    logic            owner_req;
    logic            owner_hs;
    logic            lock_last;
    logic            release_lock;

    assign req_any   = |req_i;
    assign hs        = req_any & mem_gnt_i;
    assign owner_req = req_i[lock_own_q];

    // Winner: a live lock owner keeps the port; otherwise the first request
    // found scanning upward from the round-robin pointer.
    always_comb begin
        winner = rr_ptr_q;
        cand   = '0;
        found  = 1'b0;
        if (lock_act_q && owner_req) begin
            winner = lock_own_q;
            found  = 1'b1;
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(rr_ptr_q) + i) % NumReq);
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (req_any) begin
            gnt_o[winner] = mem_gnt_i;
        end
    end

    assign mem_req_o   = req_any;
    assign mem_we_o    = we_i[winner];
    assign mem_addr_o  = addr_i[winner];
    assign mem_wdata_o = wdata_i[winner];
    assign mem_be_o    = be_i[winner];

    // Release happens when the owner stops requesting (even without a
    // handshake), lowers lock_i on its beat, or its beat uses the last slot.
    assign owner_hs     = hs & lock_act_q & owner_req;
    assign lock_last    = (32'(lock_cnt_q) + 32'd1) >= MaxLockCycles;
    assign release_lock = lock_act_q &
                          (!owner_req | (owner_hs & (!lock_i[lock_own_q] | lock_last)));

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        rsp_vld_d  = hs;
        rsp_sel_d  = hs ? winner : rsp_sel_q;

        if (release_lock) begin
            lock_act_d = 1'b0;
            lock_cnt_d = '0;
        end else if (owner_hs) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (LockEn && hs && !lock_act_q && lock_i[winner]) begin
            // Entry is gated on !lock_act_q, so a newcomer raising lock_i in
            // the cycle the previous owner releases must wait for its next beat.
            lock_act_d = 1'b1;
            lock_own_d = winner;
            lock_cnt_d = CntW'(1);
        end

        // Pointer moves past the winner so a force-released owner goes last.
        if (hs && (!lock_act_q || release_lock)) begin
            rr_ptr_d = IdxW'((32'(winner) + 32'd1) % NumReq);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_act_q <= 1'b0;
            lock_own_q <= '0;
            lock_cnt_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_sel_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_sel_q  <= rsp_sel_d;
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            rvalid_o[i] = rsp_vld_q && (rsp_sel_q == IdxW'(i));
        end
    end

    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_tile_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_tile_sram_arb
//   Directed vectors for mem_tile_sram_arb with two requesters, a 32-bit data
//   path and MaxLockCycles=8. Each table row is one clock cycle: inputs are
//   driven after the falling edge, outputs are sampled 2 ns later.
// ---------------------------------------------------------------------------
module tb_mem_tile_sram_arb;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 32;
    localparam int unsigned ML = 8;
    localparam logic [AW-1:0] A0 = 17'h00010;
    localparam logic [AW-1:0] A1 = 17'h00020;
    localparam logic [DW-1:0] WD0 = 32'h1111_1111;
    localparam logic [DW-1:0] WD1 = 32'h2222_2222;

    logic                       clk;
    logic                       rst_n;
    logic [NR-1:0]              req_i, gnt_o, we_i, lock_i, rvalid_o;
    logic [NR-1:0][AW-1:0]      addr_i;
    logic [NR-1:0][DW-1:0]      wdata_i;
    logic [NR-1:0][DW/8-1:0]    be_i;
    logic [DW-1:0]              rdata_o;
    logic                       mem_req_o, mem_gnt_i, mem_we_o;
    logic [AW-1:0]              mem_addr_o;
    logic [DW-1:0]              mem_wdata_o;
    logic [DW/8-1:0]            mem_be_o;
    logic [DW-1:0]              mem_rdata_i;

    int n_chk  = 0;
    int n_fail = 0;

    mem_tile_sram_arb #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxLockCycles(ML)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {15'd0, a};
    endfunction

    // SRAM macro model: read data one cycle after an accepted read,
    // garbage otherwise so a misrouted response is visible.
    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i && !mem_we_o) mem_rdata_i <= pat(mem_addr_o);
        else                                     mem_rdata_i <= 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    lock;
        logic [1:0]    we;
        logic          mg;
        logic [1:0]    egnt;
        logic          emreq;
        logic [AW-1:0] eaddr;
        logic [1:0]    erv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [1:0] req, input logic [1:0] lock,
                               input logic [1:0] we, input logic mg,
                               input logic [1:0] egnt, input logic emreq,
                               input logic [AW-1:0] eaddr, input logic [1:0] erv);
        vec_t r;
        r.req = req; r.lock = lock; r.we = we; r.mg = mg;
        r.egnt = egnt; r.emreq = emreq; r.eaddr = eaddr; r.erv = erv;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] lock,
                         input logic [1:0] we, input logic mg);
        req_i = req; lock_i = lock; we_i = we; mem_gnt_i = mg;
    endtask

    initial begin
        logic          prev_rd;
        logic [AW-1:0] prev_addr;
        logic          exp_we;
        logic [DW-1:0] exp_wd;

        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        addr_i  = {A1, A0};
        wdata_i = {WD1, WD0};
        be_i    = {4'hF, 4'hF};

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_mreq", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("rel_rvalid", 32'(rvalid_o), 32'd0);
        chk("rel_gnt", 32'(gnt_o), 32'd0);
        chk("rel_mreq", 32'(mem_req_o), 32'd0);

        // Round-robin fairness
        repeat (4) tbl.push_back(v(2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, A0, 2'b00));
        tbl[0].egnt = 2'b01; tbl[0].eaddr = A0; tbl[0].erv = 2'b00;
        tbl[1].egnt = 2'b10; tbl[1].eaddr = A1; tbl[1].erv = 2'b01;
        tbl[2].egnt = 2'b01; tbl[2].eaddr = A0; tbl[2].erv = 2'b10;
        tbl[3].egnt = 2'b10; tbl[3].eaddr = A1; tbl[3].erv = 2'b01;
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b10));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b00));
        // Read path, then write pass-through
        tbl.push_back(v(2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b00));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b01));
        tbl.push_back(v(2'b10, 2'b00, 2'b10, 1'b1, 2'b10, 1'b1, A1, 2'b00));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b10));
        // Full lock: 8 beats to 0, then 1, then 0 again
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b00));
        repeat (7) tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b01));
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b01));
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b10));
        // Early release: lock held 3 beats, dropped on the 4th, then 1 wins
        repeat (2) tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b01));
        tbl.push_back(v(2'b11, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b01));
        tbl.push_back(v(2'b11, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b01));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b10));
        // Stall for 5 cycles after two locked beats; still 8 beats total
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b00));
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b01));
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, A0, 2'b01));
        repeat (4) tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, A0, 2'b00));
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b00));
        repeat (5) tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b01));
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b01));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b10));
        // Owner drops req: lock releases, pointer moves on
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b00));
        tbl.push_back(v(2'b10, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b01));
        tbl.push_back(v(2'b11, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b10));
        // Release and newcomer lock in the same cycle: newcomer must not lock
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b01));
        tbl.push_back(v(2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b10));
        tbl.push_back(v(2'b10, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b01));
        tbl.push_back(v(2'b11, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, A0, 2'b10));
        // Requester 1 locks on its own later beat
        tbl.push_back(v(2'b11, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b01));
        tbl.push_back(v(2'b11, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, A1, 2'b10));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b10));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, A0, 2'b00));

        prev_rd   = 1'b0;
        prev_addr = A0;
        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].req, tbl[k].lock, tbl[k].we, tbl[k].mg);
            #2;
            exp_we = (tbl[k].eaddr == A1) ? tbl[k].we[1] : tbl[k].we[0];
            exp_wd = (tbl[k].eaddr == A1) ? WD1 : WD0;
            chk($sformatf("row%0d_gnt", k), 32'(gnt_o), 32'(tbl[k].egnt));
            chk($sformatf("row%0d_mreq", k), 32'(mem_req_o), 32'(tbl[k].emreq));
            chk($sformatf("row%0d_rvalid", k), 32'(rvalid_o), 32'(tbl[k].erv));
            if (tbl[k].emreq) begin
                chk($sformatf("row%0d_addr", k), 32'(mem_addr_o), 32'(tbl[k].eaddr));
                chk($sformatf("row%0d_we", k), 32'(mem_we_o), 32'(exp_we));
                chk($sformatf("row%0d_wdata", k), mem_wdata_o, exp_wd);
            end
            if (prev_rd) begin
                chk($sformatf("row%0d_rdata", k), rdata_o, pat(prev_addr));
            end
            prev_rd   = (tbl[k].egnt != 2'b00) && !exp_we;
            prev_addr = tbl[k].eaddr;
        end

        // Reset mid-operation: pending response dropped, pointer cleared
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 1'b1);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_rvalid_drop", 32'(rvalid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 1'b1);
        #2;
        chk("midrst_rr_clear", 32'(gnt_o), 32'b01);
        chk("midrst_rvalid_idle", 32'(rvalid_o), 32'd0);

        // Reset mid-lock: lock owned by 1 must clear
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b10, 2'b10, 2'b00, 1'b1);
        @(negedge clk);
        drive(2'b11, 2'b10, 2'b00, 1'b1);
        #2;
        chk("lock1_held", 32'(gnt_o), 32'b10);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 1'b1);
        #2;
        chk("midrst_lock_clear", 32'(gnt_o), 32'b01);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        #2;
        chk("post_rvalid", 32'(rvalid_o), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
